chisq_accum: RTL and testbench
==============================

CHISQ_ACCUM -- requirements
Module: chisq_accum

Interface
REQ-001 SHALL have parameter PARAMETERBITS, default 14: width of the chi-square result.
REQ-002 SHALL have parameter TERMBITS, default 12: width of each signed residual term, two's complement.
REQ-003 SHALL have parameter TERMS, default 6: number of terms per track.
REQ-004 SHALL have parameter SHIFT, default 10: right-shift applied to each squared term.
REQ-005 SHALL have port CLOCK, input, 1 bit: clock; all logic on the rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: reset, synchronous, active-high; clock is CLOCK.
REQ-007 SHALL have port START, input, 1 bit: begin a new track.
REQ-008 SHALL have port TERM_VALID, input, 1 bit: TERM is valid this cycle.
REQ-009 SHALL have port TERM, input, TERMBITS bits: signed residual term.
REQ-010 SHALL have port CHI, output, PARAMETERBITS bits: registered chi-square result.
REQ-011 SHALL have port CHI_VALID, output, 1 bit: one-cycle strobe; drives the CE of the downstream chi register.
REQ-012 SHALL have port BUSY, output, 1 bit: high while in ACCUM.
REQ-013 SHALL have port SAT, output, 1 bit: the current or last result saturated.

Function
REQ-014 SHALL implement the states IDLE, ACCUM and DONE.
REQ-015 IDLE: START=1 SHALL clear the accumulator, term counter and SAT, then go to ACCUM; TERM_VALID SHALL be ignored.
REQ-016 ACCUM: on each edge with TERM_VALID=1 and START=0, the block SHALL compute floor(TERM*TERM / 2^SHIFT), add it to the accumulator and increment the counter.
REQ-017 Gaps in TERM_VALID (stalls) SHALL be allowed, with the state held.
REQ-018 The square SHALL be exact and unsigned, 2*TERMBITS bits; the most negative TERM SHALL be squared correctly (-2048 gives 4194304).
REQ-019 If accumulator + shifted square > 2^PARAMETERBITS-1, the accumulator SHALL clamp to all-ones and SAT SHALL set.
REQ-020 SAT SHALL stay set until the next START or RESET.
REQ-021 Further additions to a clamped accumulator SHALL keep it clamped.
REQ-022 On the edge accepting the TERMS-th term, the block SHALL load CHI with the final sum (including that term) and go to DONE.
REQ-023 DONE SHALL last exactly one cycle: CHI_VALID=1, then unconditionally return to IDLE.
REQ-024 Latency: CHI_VALID SHALL be high in the cycle immediately after the last term's accepting edge.
REQ-025 CHI SHALL hold its value until the next DONE; CHI SHALL NOT change during ACCUM.
REQ-026 START=1 in ACCUM SHALL abort the track: clear the accumulator, counter and SAT, stay in ACCUM, and discard any term in that cycle; no CHI_VALID SHALL be issued for the aborted track.
REQ-027 START=1 in DONE SHALL be honoured: CHI_VALID is still issued this cycle, and the next state is ACCUM with cleared accumulator, counter and SAT.
REQ-028 START and TERM_VALID in the same IDLE cycle: START SHALL win and the term SHALL be discarded.
REQ-029 CHI_VALID SHALL never be high on two consecutive cycles.
REQ-030 BUSY SHALL be 1 exactly in ACCUM.

Reset
REQ-031 RESET=1 at a rising edge SHALL force IDLE with CHI=0, CHI_VALID=0, BUSY=0, SAT=0, accumulator=0 and counter=0, from any state.
REQ-032 RESET SHALL take priority over START and TERM_VALID.
REQ-033 RESET asserted mid-ACCUM SHALL produce no CHI_VALID for that track.

Verification
REQ-034 START, then six terms of +1024 -> CHI=6144, SAT=0, CHI_VALID high exactly one cycle after the sixth term.
REQ-035 START, then six terms of -32 with one idle cycle between each -> CHI=6, BUSY high throughout the track.
REQ-036 START, then six terms of -2048 -> CHI=16383, SAT=1; SAT stays 1 until the next START.
REQ-037 START, then six terms of +31 -> CHI=0, since every square truncates to zero.
REQ-038 START, three terms of 500, START again, then six terms of 64 -> CHI=24 and only one CHI_VALID pulse.
REQ-039 RESET during ACCUM after four terms -> the next cycle shows BUSY=0, CHI=0, CHI_VALID=0; two further TERM_VALID pulses produce no output.

Source files
------------

// File: rtl/chisq_accum.sv
// Chi-square accumulator: sums floor(TERM^2 / 2^SHIFT) over TERMS residuals per track,
// saturating at the result width, and presents the registered total with a one-cycle strobe.
module chisq_accum #(
  parameter int unsigned PARAMETERBITS = 14,
  parameter int unsigned TERMBITS      = 12,
  parameter int unsigned TERMS         = 6,
  parameter int unsigned SHIFT         = 10
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     TERM_VALID,
  input  logic [TERMBITS-1:0]      TERM,
  output logic [PARAMETERBITS-1:0] CHI,
  output logic                     CHI_VALID,
  output logic                     BUSY,
  output logic                     SAT
);

  localparam int unsigned SQW  = 2 * TERMBITS;
  localparam int unsigned SUMW = ((SQW > PARAMETERBITS) ? SQW : PARAMETERBITS) + 1;
  localparam int unsigned CNTW = (TERMS > 1) ? $clog2(TERMS + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]               state;
  logic [PARAMETERBITS-1:0] acc;
  logic [CNTW-1:0]          cnt;
  logic                     sat_q;
  logic [PARAMETERBITS-1:0] chi_q;

  logic [TERMBITS-1:0]      mag;
  logic [SQW-1:0]           sq;
  logic [SQW-1:0]           sq_shifted;
  logic [SUMW-1:0]          sum;
  logic                     overflow;
  logic [PARAMETERBITS-1:0] acc_next;
  logic                     last_term;

  // Magnitude is taken as unsigned so the most negative input squares exactly.
  always_comb begin
    mag        = TERM[TERMBITS-1] ? (~TERM + 1'b1) : TERM;
    sq         = {{TERMBITS{1'b0}}, mag} * {{TERMBITS{1'b0}}, mag};
    sq_shifted = sq >> SHIFT;
    sum        = SUMW'(acc) + SUMW'(sq_shifted);
    overflow   = |sum[SUMW-1:PARAMETERBITS];
    acc_next   = overflow ? '1 : sum[PARAMETERBITS-1:0];
    last_term  = (cnt == CNTW'(TERMS - 1));
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat_q <= 1'b0;
      chi_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            acc   <= '0;
            cnt   <= '0;
            sat_q <= 1'b0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (START) begin
            acc   <= '0;
            cnt   <= '0;
            sat_q <= 1'b0;
          end else if (TERM_VALID) begin
            acc   <= acc_next;
            cnt   <= cnt + 1'b1;
            sat_q <= sat_q | overflow;
            if (last_term) begin
              chi_q <= acc_next;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (START) begin
            acc   <= '0;
            cnt   <= '0;
            sat_q <= 1'b0;
            state <= ACCUM;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign CHI       = chi_q;
  assign SAT       = sat_q;
  assign CHI_VALID = (state == DONE);
  assign BUSY      = (state == ACCUM);

endmodule

// File: tb/tb_chisq_accum.sv
// Directed bench for chisq_accum: table of full tracks plus hand sequences for
// abort, reset, START-in-DONE and START-with-term-in-IDLE corner cases.
module tb_chisq_accum;

  logic               clock;
  logic               reset;
  logic               start;
  logic               term_valid;
  logic signed [11:0] term;
  logic [13:0]        chi;
  logic               chi_valid;
  logic               busy;
  logic               sat;

  int n_cmp = 0;
  int n_bad = 0;

  chisq_accum #(
    .PARAMETERBITS(14),
    .TERMBITS(12),
    .TERMS(6),
    .SHIFT(10)
  ) dut (
    .CLOCK(clock),
    .RESET(reset),
    .START(start),
    .TERM_VALID(term_valid),
    .TERM(term),
    .CHI(chi),
    .CHI_VALID(chi_valid),
    .BUSY(busy),
    .SAT(sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic signed [11:0] t;
    int                 n;
    bit                 gap;
    int                 exp_chi;
    bit                 exp_sat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs START then n terms; checks strobe timing, CHI stability and final result.
  task automatic run_track(input logic signed [11:0] t, input int n, input bit gap,
                           input int exp_chi, input bit exp_sat);
    int prev;
    prev  = int'(chi);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_sat_clr", int'(sat), 0);
    chk("start_no_valid", int'(chi_valid), 0);
    for (int i = 0; i < n; i++) begin
      term       = t;
      term_valid = 1'b1;
      tick();
      term_valid = 1'b0;
      if (i < n - 1) begin
        chk("accum_busy", int'(busy), 1);
        chk("accum_no_valid", int'(chi_valid), 0);
        chk("accum_chi_hold", int'(chi), prev);
        if (gap) begin
          tick();
          chk("gap_busy", int'(busy), 1);
          chk("gap_no_valid", int'(chi_valid), 0);
        end
      end
    end
    chk("done_valid", int'(chi_valid), 1);
    chk("done_busy", int'(busy), 0);
    chk("done_chi", int'(chi), exp_chi);
    chk("done_sat", int'(sat), int'(exp_sat));
    tick();
    chk("post_valid", int'(chi_valid), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_chi_hold", int'(chi), exp_chi);
  endtask

  initial begin
    vecs[0] = '{t: 12'sd1024,  n: 6, gap: 1'b0, exp_chi: 6144,  exp_sat: 1'b0};
    vecs[1] = '{t: -12'sd32,   n: 6, gap: 1'b1, exp_chi: 6,     exp_sat: 1'b0};
    vecs[2] = '{t: -12'sd2048, n: 6, gap: 1'b0, exp_chi: 16383, exp_sat: 1'b1};
    vecs[3] = '{t: 12'sd31,    n: 6, gap: 1'b0, exp_chi: 0,     exp_sat: 1'b0};
    vecs[4] = '{t: 12'sd500,   n: 6, gap: 1'b1, exp_chi: 1464,  exp_sat: 1'b0};

    reset = 1'b1; start = 1'b0; term_valid = 1'b0; term = '0;
    tick();
    tick();
    chk("rst_chi", int'(chi), 0);
    chk("rst_valid", int'(chi_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sat", int'(sat), 0);
    reset = 1'b0;
    tick();

    // Terms in IDLE without START are ignored.
    term = 12'sd1024; term_valid = 1'b1;
    tick(); tick();
    term_valid = 1'b0;
    chk("idle_ignore_busy", int'(busy), 0);
    chk("idle_ignore_valid", int'(chi_valid), 0);

    for (int v = 0; v < 5; v++) begin
      run_track(vecs[v].t, vecs[v].n, vecs[v].gap, vecs[v].exp_chi, vecs[v].exp_sat);
      if (vecs[v].exp_sat) begin
        tick();
        chk("sat_hold_idle", int'(sat), 1);
        tick();
        chk("sat_hold_idle2", int'(sat), 1);
      end
    end

    // Abort: three terms of 500, START again with a term present, then six of 64.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      term = 12'sd500; term_valid = 1'b1; tick();
      chk("abort_pre_valid", int'(chi_valid), 0);
    end
    start = 1'b1; term = 12'sd500; term_valid = 1'b1; tick();
    start = 1'b0; term_valid = 1'b0;
    chk("abort_busy", int'(busy), 1);
    chk("abort_valid", int'(chi_valid), 0);
    for (int i = 0; i < 6; i++) begin
      term = 12'sd64; term_valid = 1'b1; tick();
      term_valid = 1'b0;
      chk("abort_trk_valid", int'(chi_valid), (i == 5) ? 1 : 0);
    end
    chk("abort_chi", int'(chi), 24);
    tick();
    chk("abort_single_pulse", int'(chi_valid), 0);

    // START with a term in the same IDLE cycle: term is discarded.
    start = 1'b1; term = 12'sd1024; term_valid = 1'b1; tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      term = 12'sd64; term_valid = 1'b1; tick();
      term_valid = 1'b0;
      chk("idle_start_term_valid", int'(chi_valid), (i == 5) ? 1 : 0);
    end
    chk("idle_start_term_chi", int'(chi), 24);
    tick();

    // START while in DONE: strobe still issued, new track starts cleared.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      term = -12'sd2048; term_valid = 1'b1; tick();
    end
    term_valid = 1'b0;
    start = 1'b1;
    chk("done_start_valid", int'(chi_valid), 1);
    chk("done_start_chi", int'(chi), 16383);
    tick();
    start = 1'b0;
    chk("done_start_busy", int'(busy), 1);
    chk("done_start_nvalid", int'(chi_valid), 0);
    chk("done_start_sat_clr", int'(sat), 0);
    for (int i = 0; i < 6; i++) begin
      term = -12'sd32; term_valid = 1'b1; tick();
      term_valid = 1'b0;
    end
    chk("done_start_trk_valid", int'(chi_valid), 1);
    chk("done_start_trk_chi", int'(chi), 6);
    tick();

    // Reset mid-ACCUM after four terms.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      term = 12'sd1024; term_valid = 1'b1; tick();
    end
    reset = 1'b1; start = 1'b1; term_valid = 1'b1; tick();
    reset = 1'b0; start = 1'b0; term_valid = 1'b0;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_chi", int'(chi), 0);
    chk("rst_mid_valid", int'(chi_valid), 0);
    chk("rst_mid_sat", int'(sat), 0);
    for (int i = 0; i < 2; i++) begin
      term = 12'sd1024; term_valid = 1'b1; tick();
      term_valid = 1'b0;
      chk("rst_after_valid", int'(chi_valid), 0);
      chk("rst_after_busy", int'(busy), 0);
      tick();
      chk("rst_after_valid2", int'(chi_valid), 0);
    end
    chk("rst_after_chi", int'(chi), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
